wisard_stream_core: RTL and testbench
=====================================

// Module: wisard_stream_core
// PURPOSE
//  Parametrised successor to the WiSARD inference top. Accepts an input address stream IN_WIDTH bits per beat
//  under valid/ready, reassembles ADDRESS_WIDTH-bit RAM addresses and drives an external combinational LUT.
//  Accumulates per-class hit scores over N_RAMS addresses, then runs a sequential argmax.
//  Returns class, best score and margin under valid/ready backpressure.
// PARAMETERS
//  ADDRESS_WIDTH 8   bits per RAM address
//  IN_WIDTH      1   bits per input beat; must divide ADDRESS_WIDTH; BEATS = ADDRESS_WIDTH/IN_WIDTH
//  N_RAMS        16  addresses (RAMs) per sample
//  INDEX_WIDTH   4   width of RAM index; 2**INDEX_WIDTH >= N_RAMS
//  N_CLASSES     10  number of discriminators
//  CLASS_WIDTH   4   width of class id; 2**CLASS_WIDTH >= N_CLASSES
//  SCORE_WIDTH   localparam = clog2(N_RAMS+1); score counters never overflow
// PORTS
//  clk           in  1              clock
//  rst_n         in  1              reset, asynchronous, active-low
//  sink_valid    in  1              input beat valid
//  sink_ready    out 1              core accepts beat; beat transfers when valid&ready
//  sink_sop      in  1              beat is first of a sample
//  sink_data     in  IN_WIDTH       address bits; first beat of an address -> LSBs
//  lut_addr      out ADDRESS_WIDTH  registered reassembled address
//  lut_index     out INDEX_WIDTH    RAM index of lut_addr
//  lut_hit       in  N_CLASSES      combinational LUT response to lut_addr/lut_index, same cycle
//  source_valid  out 1              result valid; held until source_ready
//  source_ready  in  1              downstream accepts result
//  source_class  out CLASS_WIDTH    winning class
//  source_score  out SCORE_WIDTH    winning score
//  source_margin out SCORE_WIDTH    best minus second-best score (= best if N_CLASSES==1)
//  source_err    out 1              sample saw protocol error (see below)
// BEHAVIOUR
//  Reset: all outputs 0 except sink_ready=1; state IDLE; counters, beat/ram counters, err cleared.
//  States: IDLE -> ACCUM -> FLUSH -> ARGMAX -> RESULT -> IDLE.
//  sink_ready = 1 in IDLE/ACCUM, else 0.
//  IDLE: beat with sop -> clear scores/err, load beat, go ACCUM. Beat without sop -> dropped, err_pending set
//   (reported in source_err of the next result).
//  ACCUM: each accepted beat shifts into the assembler.
//   On BEATS-th beat the address is registered: lut_addr/lut_index valid next cycle for exactly one cycle (addr_vld).
//   In an addr_vld cycle, score[c] += lut_hit[c] for every c. lut_index increments after each address; 0 at sop.
//  Last beat of address N_RAMS-1 accepted at T: FLUSH at T+1 (final addr_vld, scores updated).
//  ARGMAX: cycles T+2..T+1+N_CLASSES, one class compared per cycle, ascending index.
//   Strict '>' update: ties -> lowest class index wins. Second-best tracked in parallel.
//  RESULT: source_valid=1 from cycle T+2+N_CLASSES. Outputs stable while source_ready=0.
//   valid&ready -> IDLE next cycle; source_valid drops; sink_ready=1 same edge.
//  sop in ACCUM (mid-sample): partial sample discarded, restart with that beat as first, err set for new sample.
//  lut_hit ignored outside addr_vld cycles. sink_* ignored when sink_ready=0.
//  Reset asserted mid-operation: immediate return to reset state, partial sample lost, no result emitted.
//  Counter wraps: beat counter 0..BEATS-1, ram counter 0..N_RAMS-1; no wrap of scores by construction.
// STRUCTURE
//  wisard_pkg: state enum (IDLE..RESULT), clog2 function, BEATS/SCORE_WIDTH derivation helpers.
//  Sub-module wisard_argmax_seq: sequential best/second-best scan over score vector.
//   start/done handshake, tie rule as above.
//  Top holds assembler, index counter, score counters, FSM, output register.
// TESTING
//  1 IN_WIDTH=1, sample with lut_hit one-hot class 3 every address -> class=3, score=16, margin=16, err=0,
//    source_valid at T+2+N_CLASSES.
//  2 Classes 2 and 5 both score 9, others <9 -> class=2, score=9, margin=0.
//  3 source_ready held 0 for 20 cycles -> outputs stable, sink_ready=0; on ready, IDLE next cycle,
//    back-to-back sample accepted with no gap.
//  4 sop re-asserted after 7 addresses -> only the restarted sample is scored; source_err=1.
//  5 IN_WIDTH=4, ADDRESS_WIDTH=8: beats 0xA then 0x5 -> lut_addr=0x5A, lut_index=0.
//    Random sink_valid gaps give results identical to a gapless stream.
//  6 rst_n low during ARGMAX -> no source_valid; all outputs 0, sink_ready=1; next sample correct.

Source files
------------

// File: rtl/wisard_pkg.sv
// Shared types and elaboration-time helpers for the WiSARD streaming core.
package wisard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FLUSH,
    ST_ARGMAX,
    ST_RESULT
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic int unsigned beats(input int unsigned aw, input int unsigned iw);
    return aw / iw;
  endfunction

  // Wide enough to hold a count of 0..n_rams without wrapping.
  function automatic int unsigned score_width(input int unsigned n_rams);
    return clog2(n_rams + 1);
  endfunction

  // Counter width for 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wisard_argmax_seq.sv
// Sequential argmax: scans one class per cycle in ascending order, tracking
// best and second-best scores. Strict '>' keeps the lowest index on ties.
// result outputs are valid in the done_o cycle and include that cycle's compare.
module wisard_argmax_seq #(
  parameter int unsigned N_CLASSES   = 10,
  parameter int unsigned CLASS_WIDTH = 4,
  parameter int unsigned SCORE_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [SCORE_WIDTH-1:0] scores_i [N_CLASSES],
  output logic                   done_o,
  output logic [CLASS_WIDTH-1:0] class_o,
  output logic [SCORE_WIDTH-1:0] score_o,
  output logic [SCORE_WIDTH-1:0] margin_o
);

  logic                   busy_q;
  logic [CLASS_WIDTH-1:0] idx_q;
  logic [CLASS_WIDTH-1:0] cls_q, cls_d;
  logic [SCORE_WIDTH-1:0] best_q, best_d;
  logic [SCORE_WIDTH-1:0] second_q, second_d;
  logic [SCORE_WIDTH-1:0] cur;

  assign cur      = scores_i[idx_q];
  assign done_o   = busy_q && (idx_q == CLASS_WIDTH'(N_CLASSES - 1));
  assign class_o  = cls_d;
  assign score_o  = best_d;
  assign margin_o = best_d - second_d;

  // Compare the current class against the running best / second-best.
  always_comb begin
    cls_d    = cls_q;
    best_d   = best_q;
    second_d = second_q;
    if (idx_q == '0) begin
      cls_d    = '0;
      best_d   = cur;
      second_d = '0;
    end else if (cur > best_q) begin
      cls_d    = idx_q;
      best_d   = cur;
      second_d = best_q;
    end else if (cur > second_q) begin
      second_d = cur;
    end
  end

  // Scan control and running-result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      idx_q    <= '0;
      cls_q    <= '0;
      best_q   <= '0;
      second_q <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      idx_q  <= '0;
    end else if (busy_q) begin
      cls_q    <= cls_d;
      best_q   <= best_d;
      second_q <= second_d;
      if (done_o) begin
        busy_q <= 1'b0;
        idx_q  <= '0;
      end else begin
        idx_q <= idx_q + CLASS_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/wisard_stream_core.sv
// WiSARD streaming inference core: reassembles LUT addresses from a beat
// stream, accumulates per-class hits, then runs a sequential argmax and
// presents class / score / margin under valid/ready.
module wisard_stream_core
  import wisard_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned IN_WIDTH      = 1,
  parameter int unsigned N_RAMS        = 16,
  parameter int unsigned INDEX_WIDTH   = 4,
  parameter int unsigned N_CLASSES     = 10,
  parameter int unsigned CLASS_WIDTH   = 4,
  localparam int unsigned SCORE_WIDTH  = score_width(N_RAMS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sink_valid,
  output logic                     sink_ready,
  input  logic                     sink_sop,
  input  logic [IN_WIDTH-1:0]      sink_data,
  output logic [ADDRESS_WIDTH-1:0] lut_addr,
  output logic [INDEX_WIDTH-1:0]   lut_index,
  input  logic [N_CLASSES-1:0]     lut_hit,
  output logic                     source_valid,
  input  logic                     source_ready,
  output logic [CLASS_WIDTH-1:0]   source_class,
  output logic [SCORE_WIDTH-1:0]   source_score,
  output logic [SCORE_WIDTH-1:0]   source_margin,
  output logic                     source_err
);

  localparam int unsigned BEATS = beats(ADDRESS_WIDTH, IN_WIDTH);
  localparam int unsigned BW    = cnt_width(BEATS);
  localparam int unsigned RW    = cnt_width(N_RAMS);

  state_e                   state_q, state_d;
  logic [BW-1:0]            beat_q, eff_beat;
  logic [RW-1:0]            ram_q, eff_ram;
  logic [ADDRESS_WIDTH-1:0] asm_q, asm_next, lut_addr_q;
  logic [INDEX_WIDTH-1:0]   lut_index_q;
  logic                     addr_vld_q;
  logic [SCORE_WIDTH-1:0]   score_q [N_CLASSES];
  logic                     err_q, err_pending_q;
  logic [CLASS_WIDTH-1:0]   res_class_q;
  logic [SCORE_WIDTH-1:0]   res_score_q, res_margin_q;
  logic                     res_err_q;

  logic                     beat_fire, sop_fire, accept, addr_done, last_beat;
  logic                     scan_start, scan_done;
  logic [CLASS_WIDTH-1:0]   scan_class;
  logic [SCORE_WIDTH-1:0]   scan_score, scan_margin;

  assign sink_ready = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign beat_fire  = sink_valid && sink_ready;
  assign sop_fire   = beat_fire && sink_sop;
  assign accept     = sop_fire || (beat_fire && (state_q == ST_ACCUM));
  // A sop beat always counts as beat 0 of address 0, even mid-sample.
  assign eff_beat   = sop_fire ? '0 : beat_q;
  assign eff_ram    = sop_fire ? '0 : ram_q;
  assign addr_done  = accept && (eff_beat == BW'(BEATS - 1));
  assign last_beat  = addr_done && (eff_ram == RW'(N_RAMS - 1));

  // First beat ends up in the LSBs: each new beat enters at the top.
  if (BEATS == 1) begin : g_asm_single
    assign asm_next = sink_data;
  end else begin : g_asm_shift
    assign asm_next = {sink_data, asm_q[ADDRESS_WIDTH-1:IN_WIDTH]};
  end

  assign lut_addr      = lut_addr_q;
  assign lut_index     = lut_index_q;
  assign source_valid  = (state_q == ST_RESULT);
  assign source_class  = res_class_q;
  assign source_score  = res_score_q;
  assign source_margin = res_margin_q;
  assign source_err    = res_err_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state and scan start.
  always_comb begin
    state_d    = state_q;
    scan_start = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (sop_fire) state_d = last_beat ? ST_FLUSH : ST_ACCUM;
      ST_ACCUM:  if (last_beat) state_d = ST_FLUSH;
      ST_FLUSH: begin
        scan_start = 1'b1;
        state_d    = ST_ARGMAX;
      end
      ST_ARGMAX: if (scan_done) state_d = ST_RESULT;
      ST_RESULT: if (source_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Beat assembler, beat/RAM counters and registered LUT address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q       <= '0;
      beat_q      <= '0;
      ram_q       <= '0;
      lut_addr_q  <= '0;
      lut_index_q <= '0;
      addr_vld_q  <= 1'b0;
    end else begin
      addr_vld_q <= addr_done;
      if (accept) begin
        asm_q  <= asm_next;
        beat_q <= addr_done ? '0 : eff_beat + BW'(1);
      end
      if (addr_done) begin
        lut_addr_q  <= asm_next;
        lut_index_q <= INDEX_WIDTH'(eff_ram);
        ram_q       <= last_beat ? '0 : eff_ram + RW'(1);
      end else if (sop_fire) begin
        ram_q       <= '0;
        lut_index_q <= '0;
      end
    end
  end

  // Per-class score accumulation; a sop clears scores ahead of any pending hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < N_CLASSES; c++) score_q[c] <= '0;
    end else if (sop_fire) begin
      for (int unsigned c = 0; c < N_CLASSES; c++) score_q[c] <= '0;
    end else if (addr_vld_q) begin
      for (int unsigned c = 0; c < N_CLASSES; c++)
        score_q[c] <= score_q[c] + SCORE_WIDTH'(lut_hit[c]);
    end
  end

  // Protocol error tracking: stray beats in IDLE flag the next sample,
  // a restart mid-sample flags the restarted one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q         <= 1'b0;
      err_pending_q <= 1'b0;
    end else if (sop_fire) begin
      err_q         <= (state_q == ST_ACCUM) || err_pending_q;
      err_pending_q <= 1'b0;
    end else if (beat_fire && (state_q == ST_IDLE)) begin
      err_pending_q <= 1'b1;
    end
  end

  // Result register, loaded on the final argmax compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_class_q  <= '0;
      res_score_q  <= '0;
      res_margin_q <= '0;
      res_err_q    <= 1'b0;
    end else if (scan_done) begin
      res_class_q  <= scan_class;
      res_score_q  <= scan_score;
      res_margin_q <= scan_margin;
      res_err_q    <= err_q;
    end
  end

  wisard_argmax_seq #(
    .N_CLASSES  (N_CLASSES),
    .CLASS_WIDTH(CLASS_WIDTH),
    .SCORE_WIDTH(SCORE_WIDTH)
  ) u_argmax (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (scan_start),
    .scores_i(score_q),
    .done_o  (scan_done),
    .class_o (scan_class),
    .score_o (scan_score),
    .margin_o(scan_margin)
  );

endmodule

// File: tb/tb_wisard_stream_core.sv
// Directed bench for wisard_stream_core: default 1-bit beat instance plus a
// 4-bit beat instance for address reassembly.
module tb_wisard_stream_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sink_valid, sink_ready, sink_sop;
  logic [0:0] sink_data;
  logic [7:0] lut_addr;
  logic [3:0] lut_index;
  logic [9:0] lut_hit;
  logic       source_valid, source_ready;
  logic [3:0] source_class;
  logic [4:0] source_score, source_margin;
  logic       source_err;

  logic       s4_valid, s4_ready, s4_sop;
  logic [3:0] s4_data;
  logic [7:0] lut_addr4;
  logic [3:0] lut_index4;
  logic [9:0] lut_hit4;
  logic       src4_valid;
  logic [3:0] src4_class;
  logic [4:0] src4_score, src4_margin;
  logic       src4_err;

  int mode;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // mode 0: class 3 hits everywhere
  // mode 1: c2,c5 hit idx<9; c7 idx<8; c0 idx<4
  // mode 2: class c hits when addr == {A, c}
  function automatic logic [9:0] lut_model(input int m, input logic [7:0] a, input logic [3:0] idx);
    logic [9:0] h;
    h = '0;
    case (m)
      0: h[3] = 1'b1;
      1: begin
        h[2] = (idx < 4'd9);
        h[5] = (idx < 4'd9);
        h[7] = (idx < 4'd8);
        h[0] = (idx < 4'd4);
      end
      default:
        for (int c = 0; c < 10; c++) h[c] = (a[7:4] == 4'hA) && (a[3:0] == 4'(c));
    endcase
    return h;
  endfunction

  assign lut_hit  = lut_model(mode, lut_addr, lut_index);
  assign lut_hit4 = '0;

  wisard_stream_core dut (
    .clk(clk), .rst_n(rst_n),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop), .sink_data(sink_data),
    .lut_addr(lut_addr), .lut_index(lut_index), .lut_hit(lut_hit),
    .source_valid(source_valid), .source_ready(source_ready),
    .source_class(source_class), .source_score(source_score),
    .source_margin(source_margin), .source_err(source_err)
  );

  wisard_stream_core #(.IN_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .sink_valid(s4_valid), .sink_ready(s4_ready), .sink_sop(s4_sop), .sink_data(s4_data),
    .lut_addr(lut_addr4), .lut_index(lut_index4), .lut_hit(lut_hit4),
    .source_valid(src4_valid), .source_ready(1'b0),
    .source_class(src4_class), .source_score(src4_score),
    .source_margin(src4_margin), .source_err(src4_err)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [7:0] addr_of(input int m, input int i);
    if (m == 2) return {4'hA, 4'(i % 5)};
    return 8'(i * 37 + 5);
  endfunction

  task automatic send_beat(input logic sop, input logic d);
    sink_valid = 1'b1;
    sink_sop   = sop;
    sink_data  = d;
    @(posedge clk); #1;
  endtask

  task automatic send_sample(input int nram, input bit gaps);
    logic [7:0] a;
    for (int i = 0; i < nram; i++) begin
      a = addr_of(mode, i);
      for (int b = 0; b < 8; b++) begin
        if (gaps && ($urandom_range(0, 2) == 0)) begin
          sink_valid = 1'b0;
          @(posedge clk); #1;
        end
        send_beat((i == 0) && (b == 0), a[b]);
      end
    end
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 60; i++) begin
      if (source_valid) break;
      @(posedge clk); #1;
    end
    chk(name, 32'(source_valid), 32'd1);
  endtask

  task automatic handshake();
    source_ready = 1'b1;
    @(posedge clk); #1;
    source_ready = 1'b0;
  endtask

  task automatic chk_result(input string name, input logic [3:0] c, input logic [4:0] s,
                            input logic [4:0] m, input logic e);
    chk({name, "_class"},  32'(source_class),  32'(c));
    chk({name, "_score"},  32'(source_score),  32'(s));
    chk({name, "_margin"}, 32'(source_margin), 32'(m));
    chk({name, "_err"},    32'(source_err),    32'(e));
  endtask

  initial begin
    rst_n = 1'b0; sink_valid = 1'b0; sink_sop = 1'b0; sink_data = '0; source_ready = 1'b0;
    s4_valid = 1'b0; s4_sop = 1'b0; s4_data = '0; mode = 0;
    #12;
    chk("rst_sink_ready", 32'(sink_ready), 32'd1);
    chk("rst_outputs", {lut_addr, lut_index, source_valid, source_class, source_score, source_margin, source_err},
        32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: one-hot class 3, latency check
    mode = 0;
    send_sample(16, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("t1_valid_early", 32'(source_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_valid_on_time", 32'(source_valid), 32'd1);
    chk_result("t1", 4'd3, 5'd16, 5'd16, 1'b0);
    chk("t1_sink_ready", 32'(sink_ready), 32'd0);
    handshake();
    chk("t1_valid_drop", 32'(source_valid), 32'd0);
    chk("t1_sink_ready_back", 32'(sink_ready), 32'd1);

    // 2: tie between classes 2 and 5
    mode = 1;
    send_sample(16, 1'b0);
    wait_valid("t2_wait");
    chk_result("t2", 4'd2, 5'd9, 5'd0, 1'b0);

    // 3: hold under backpressure, then back-to-back sample
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("t3_hold", {source_valid, sink_ready, source_class, source_score, source_margin},
          {1'b1, 1'b0, 4'd2, 5'd9, 5'd0});
    end
    handshake();
    chk("t3_idle", {source_valid, sink_ready}, 2'b01);

    // 4: restart after 7 addresses
    mode = 0;
    send_sample(7, 1'b0);
    send_sample(16, 1'b0);
    wait_valid("t4_wait");
    chk_result("t4", 4'd3, 5'd16, 5'd16, 1'b1);
    handshake();

    // stray beat in IDLE flags the next sample only
    send_beat(1'b0, 1'b1);
    sink_valid = 1'b0;
    @(posedge clk); #1;
    send_sample(16, 1'b0);
    wait_valid("stray_wait");
    chk_result("stray", 4'd3, 5'd16, 5'd16, 1'b1);
    handshake();
    send_sample(16, 1'b0);
    wait_valid("clean_wait");
    chk("clean_err", 32'(source_err), 32'd0);
    handshake();

    // 5: 4-bit beats reassemble with first beat in LSBs
    s4_valid = 1'b1; s4_sop = 1'b1; s4_data = 4'hA;
    @(posedge clk); #1;
    s4_sop = 1'b0; s4_data = 4'h5;
    @(posedge clk); #1;
    chk("t5_addr0", 32'(lut_addr4), 32'h5A);
    chk("t5_index0", 32'(lut_index4), 32'd0);
    s4_data = 4'h3;
    @(posedge clk); #1;
    s4_data = 4'hC;
    @(posedge clk); #1;
    s4_valid = 1'b0;
    chk("t5_addr1", 32'(lut_addr4), 32'hC3);
    chk("t5_index1", 32'(lut_index4), 32'd1);

    // 5b: address-dependent LUT, gapless then with random valid gaps
    mode = 2;
    send_sample(16, 1'b0);
    wait_valid("t5_gapless_wait");
    chk_result("t5_gapless", 4'd0, 5'd4, 5'd1, 1'b0);
    handshake();
    send_sample(16, 1'b1);
    wait_valid("t5_gapped_wait");
    chk_result("t5_gapped", 4'd0, 5'd4, 5'd1, 1'b0);
    handshake();

    // 6: reset during ARGMAX
    mode = 0;
    send_sample(16, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_sink_ready", 32'(sink_ready), 32'd1);
    chk("t6_rst_outputs", {lut_addr, lut_index, source_valid, source_class, source_score, source_margin, source_err},
        32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      chk("t6_no_valid", 32'(source_valid), 32'd0);
    end
    mode = 1;
    send_sample(16, 1'b0);
    wait_valid("t6_wait");
    chk_result("t6", 4'd2, 5'd9, 5'd0, 1'b0);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
